// File: rtl/arb_mux.sv
// N-channel valid/ready arbiter feeding a single registered output slot.
// Define ARB_MUX_RR_EN for round-robin arbitration; otherwise lowest index wins.
module arb_mux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;

  logic [N-1:0]     grant;
  logic [SELW-1:0]  gnt_idx;
  logic             found;
  logic [WIDTH-1:0] mux_data;
  logic             can_accept;
  logic             xfer_in;

`ifdef ARB_MUX_RR_EN
  logic [SELW-1:0]  ptr_q;
`endif

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
`ifdef ARB_MUX_RR_EN
    // First pass looks only above the last grant; the second pass wraps around.
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && in_valid[i] && (i > 32'(ptr_q))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        gnt_idx  = SELW'(i);
      end
    end
`endif
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && in_valid[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        gnt_idx  = SELW'(i);
      end
    end
  end

  always_comb begin
    mux_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      mux_data = mux_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  assign can_accept = !out_valid_q || out_ready;
  assign in_ready   = rst ? '0 : (grant & {N{can_accept}});
  assign xfer_in    = |in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (xfer_in) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_sel_d   = gnt_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

`ifdef ARB_MUX_RR_EN
  // Reset to N-1 so the first search after reset starts at channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= SELW'(N - 1);
    end else if (xfer_in) begin
      ptr_q <= gnt_idx;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
